nclic_dispatcher: RTL and testbench

Interrupt dispatcher for the nested core-local interrupt controller. Each cycle it scans the per-interrupt configuration vector held in the CSR file and picks the highest-priority interrupt that is both pending and enabled. It offers that interrupt to the core over a valid/ready handshake and, on acceptance, clears the pending bit. It also tracks nesting with a priority stack: entries are pushed on each taken interrupt and popped on `mret`. The block sits between the interrupt CSR file and the core's trap-entry logic.

---
 rtl/types_pkg.sv | 33 +++
 rtl/nclic_prio_stack.sv | 48 ++++
 rtl/nclic_dispatcher.sv | 104 ++++++++++
 tb/tb_nclic_dispatcher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared NCLIC types: interrupt config word, index/priority widths, dispatcher state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package types_pkg;

  localparam int Priorities = 8;
  localparam int IntAmount  = 8;
  localparam int NestDepth  = Priorities - 1;
  localparam int DepthW     = $clog2(Priorities) + 1;

  typedef logic [$clog2(Priorities)-1:0] IntPrio;
  typedef logic [$clog2(IntAmount)-1:0]  IntIdx;

  typedef struct packed {
    IntPrio prio;
    logic   enabled;
    logic   pending;
  } int_config_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    COMMIT = 2'd2
  } dispatch_state_t;

  // Result of one selection scan.
  typedef struct packed {
    logic   vld;
    IntIdx  idx;
    IntPrio prio;
  } cand_t;

endpackage

// File: rtl/nclic_prio_stack.sv
// Priority LIFO recording the preemption threshold of each nested trap level.
// Latency: push/pop take effect at the clock edge; top/depth/empty/full are registered state.
// Backpressure: none; push+pop together replaces the top, push when full is dropped.
// Ports: clk, rst (async, active-high), push, pop, din -> top, depth, empty, full.
module nclic_prio_stack import types_pkg::*; #(
  parameter int Depth = NestDepth,
  parameter int DW    = DepthW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  IntPrio        din,
  output IntPrio        top,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full
);

  localparam int IW = $clog2(Depth);

  IntPrio        mem [Depth];
  logic [DW-1:0] cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == DW'(Depth));
  assign depth = cnt;
  assign top   = empty ? '0 : mem[IW'(cnt - 1'b1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      // Pop then push: depth unchanged, top overwritten.
      mem[IW'(cnt - 1'b1)] <= din;
    end else if (push && !full) begin
      mem[IW'(cnt)] <= din;
      cnt           <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Pushed priorities strictly increase, so a push into a full stack is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));

endmodule

// File: rtl/nclic_dispatcher.sv
// Picks the highest-priority pending+enabled interrupt above the current threshold and offers it to the core.
// Latency: offer registered 1 cycle after eligibility; clear pulse in the cycle after the handshake.
// Backpressure: offer held stable (no withdraw/re-select) until irq_ready_i; mret_i accepted any cycle.
// Ports: int_cfg_i (per-line cfg), irq_valid_o/irq_idx_o/irq_ready_i (offer handshake), mret_i,
//        clr_pending_o (one-hot clear), cur_prio_o/depth_o (nesting state), err_o (sticky underflow).
// Sizing (IntAmount, Priorities) comes from types_pkg.
module nclic_dispatcher import types_pkg::*; (
  input  logic                             clk,
  input  logic                             reset,
  input  int_config_t [IntAmount-1:0]      int_cfg_i,
  output logic                             irq_valid_o,
  output IntIdx                            irq_idx_o,
  input  logic                             irq_ready_i,
  input  logic                             mret_i,
  output logic        [IntAmount-1:0]      clr_pending_o,
  output IntPrio                           cur_prio_o,
  output logic        [DepthW-1:0]         depth_o,
  output logic                             err_o
);

  dispatch_state_t state, state_nxt;
  IntIdx           lat_idx;
  IntPrio          lat_prio;
  cand_t           cand;
  logic            push;
  logic            stk_empty;
  logic            stk_full;

  // Strict '>' on both comparisons: lines at or below the threshold are
  // ineligible, and equal-priority ties keep the lowest index.
  function automatic cand_t select_cand(input int_config_t [IntAmount-1:0] cfg,
                                        input IntPrio thr);
    cand_t c;
    c = '0;
    for (int i = 0; i < IntAmount; i++) begin
      if (cfg[i].pending && cfg[i].enabled && (cfg[i].prio > thr) &&
          (!c.vld || (cfg[i].prio > c.prio))) begin
        c.vld  = 1'b1;
        c.idx  = IntIdx'(i);
        c.prio = cfg[i].prio;
      end
    end
    return c;
  endfunction

  assign cand = select_cand(int_cfg_i, cur_prio_o);
  assign push = (state == OFFER) && irq_ready_i;

  always_comb begin
    state_nxt     = state;
    irq_valid_o   = 1'b0;
    clr_pending_o = '0;
    unique case (state)
      IDLE:   if (cand.vld) state_nxt = OFFER;
      OFFER: begin
        irq_valid_o = 1'b1;
        if (irq_ready_i) state_nxt = COMMIT;
      end
      COMMIT: begin
        clr_pending_o[lat_idx] = 1'b1;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_idx  <= '0;
      lat_prio <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cand.vld) begin
        lat_idx  <= cand.idx;
        lat_prio <= cand.prio;
      end
      if (mret_i && stk_empty) err_o <= 1'b1;
    end
  end

  assign irq_idx_o = lat_idx;

  nclic_prio_stack #(
    .Depth (NestDepth),
    .DW    (DepthW)
  ) u_stack (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (mret_i),
    .din   (lat_prio),
    .top   (cur_prio_o),
    .depth (depth_o),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // Full is only observed by the stack's own overflow check.
  logic unused_full;
  assign unused_full = stk_full;

endmodule

// File: tb/tb_nclic_dispatcher.sv
// Directed bench for nclic_dispatcher: selection, handshake, nesting, underflow, hold, async reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that same point.
// The bench plays the CSR file by clearing pending bits itself.
module tb_nclic_dispatcher;
  import types_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  int_config_t [IntAmount-1:0] cfg;
  logic                        irq_valid;
  IntIdx                       irq_idx;
  logic                        irq_ready;
  logic                        mret;
  logic [IntAmount-1:0]        clr_pending;
  IntPrio                      cur_prio;
  logic [DepthW-1:0]           depth;
  logic                        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nclic_dispatcher dut (
    .clk           (clk),
    .reset         (reset),
    .int_cfg_i     (cfg),
    .irq_valid_o   (irq_valid),
    .irq_idx_o     (irq_idx),
    .irq_ready_i   (irq_ready),
    .mret_i        (mret),
    .clr_pending_o (clr_pending),
    .cur_prio_o    (cur_prio),
    .depth_o       (depth),
    .err_o         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    cfg       = '0;
    irq_ready = 1'b0;
    mret      = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_line(input int idx, input int prio);
    cfg[idx] = '{prio: IntPrio'(prio), enabled: 1'b1, pending: 1'b1};
  endtask

  task automatic test_reset();
    cfg = '0; irq_ready = 1'b0; mret = 1'b0; reset = 1'b1;
    tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", irq_valid); end
    checks++; if (irq_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", irq_idx); end
    checks++; if (clr_pending !== 8'h00) begin errors++; $display("FAIL rst_clr: got %h want 00", clr_pending); end
    checks++; if (cur_prio !== 3'd0) begin errors++; $display("FAIL rst_prio: got %0d want 0", cur_prio); end
    checks++; if (depth !== 4'd0) begin errors++; $display("FAIL rst_depth: got %0d want 0", depth); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_single_line();
    reset_dut();
    set_line(3, 5);
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd3) begin errors++; $display("FAIL single_offer: got v=%0b idx=%0d want v=1 idx=3", irq_valid, irq_idx); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (clr_pending !== 8'b0000_1000) begin errors++; $display("FAIL single_clr: got %b want 00001000", clr_pending); end
    checks++; if (cur_prio !== 3'd5 || depth !== 4'd1) begin errors++; $display("FAIL single_stack: got prio=%0d depth=%0d want 5/1", cur_prio, depth); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %0b want 0", irq_valid); end
    cfg[3].pending = 1'b0;
    tick();
    checks++; if (clr_pending !== 8'h00) begin errors++; $display("FAIL single_clr_once: got %b want 00000000", clr_pending); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (depth !== 4'd0 || cur_prio !== 3'd0) begin errors++; $display("FAIL single_mret: got depth=%0d prio=%0d want 0/0", depth, cur_prio); end
  endtask

  task automatic test_selection();
    reset_dut();
    set_line(1, 4);
    set_line(6, 4);
    set_line(2, 2);
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd1) begin errors++; $display("FAIL sel_tie: got v=%0b idx=%0d want v=1 idx=1", irq_valid, irq_idx); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (clr_pending !== 8'b0000_0010 || cur_prio !== 3'd4) begin errors++; $display("FAIL sel_take: got clr=%b prio=%0d want 00000010/4", clr_pending, cur_prio); end
    cfg[1].pending = 1'b0;
    tick();
    tick();
    // Line 6 sits at prio 4, equal to the threshold, so it must not be offered.
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL sel_equal_blocked: got %0b want 0", irq_valid); end
  endtask

  task automatic test_nesting();
    reset_dut();
    set_line(0, 2);
    tick();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (depth !== 4'd1 || cur_prio !== 3'd2) begin errors++; $display("FAIL nest_first: got depth=%0d prio=%0d want 1/2", depth, cur_prio); end
    cfg[0].pending = 1'b0;
    set_line(5, 6);
    tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL nest_gap: got %0b want 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd5) begin errors++; $display("FAIL nest_offer: got v=%0b idx=%0d want v=1 idx=5", irq_valid, irq_idx); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (depth !== 4'd2 || cur_prio !== 3'd6 || clr_pending !== 8'b0010_0000) begin errors++; $display("FAIL nest_second: got depth=%0d prio=%0d clr=%b want 2/6/00100000", depth, cur_prio, clr_pending); end
    cfg[5].pending = 1'b0;
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (depth !== 4'd1 || cur_prio !== 3'd2) begin errors++; $display("FAIL nest_mret: got depth=%0d prio=%0d want 1/2", depth, cur_prio); end
    set_line(4, 2);
    tick();
    tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL nest_masked: got %0b want 0", irq_valid); end
  endtask

  task automatic test_underflow();
    reset_dut();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (err !== 1'b1 || depth !== 4'd0) begin errors++; $display("FAIL uflow_set: got err=%0b depth=%0d want 1/0", err, depth); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL uflow_sticky: got %0b want 1", err); end
    reset_dut();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL uflow_clear: got %0b want 0", err); end
  endtask

  task automatic test_hold_and_reset();
    reset_dut();
    set_line(2, 3);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) cfg[2].pending = 1'b0;
      tick();
      checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd2) begin errors++; $display("FAIL hold_%0d: got v=%0b idx=%0d want v=1 idx=2", i, irq_valid, irq_idx); end
    end
    cfg[2].pending = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (irq_valid !== 1'b0 || clr_pending !== 8'h00 || depth !== 4'd0) begin errors++; $display("FAIL hold_async_rst: got v=%0b clr=%b depth=%0d want 0/00000000/0", irq_valid, clr_pending, depth); end
    irq_ready = 1'b1;
    tick();
    reset = 1'b0;
    irq_ready = 1'b0;
    cfg = '0;
    checks++; if (clr_pending !== 8'h00 || irq_valid !== 1'b0) begin errors++; $display("FAIL hold_no_clr: got clr=%b v=%0b want 00000000/0", clr_pending, irq_valid); end
    tick();
    checks++; if (clr_pending !== 8'h00) begin errors++; $display("FAIL hold_no_clr_after: got %b want 00000000", clr_pending); end
  endtask

  task automatic test_coincident();
    reset_dut();
    set_line(1, 3);
    tick();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    cfg[1].pending = 1'b0;
    checks++; if (depth !== 4'd1 || cur_prio !== 3'd3) begin errors++; $display("FAIL coin_setup: got depth=%0d prio=%0d want 1/3", depth, cur_prio); end
    set_line(7, 7);
    tick();
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd7) begin errors++; $display("FAIL coin_offer: got v=%0b idx=%0d want v=1 idx=7", irq_valid, irq_idx); end
    irq_ready = 1'b1;
    mret = 1'b1;
    tick();
    irq_ready = 1'b0;
    mret = 1'b0;
    checks++; if (depth !== 4'd1 || cur_prio !== 3'd7 || clr_pending !== 8'b1000_0000) begin errors++; $display("FAIL coin_replace: got depth=%0d prio=%0d clr=%b want 1/7/10000000", depth, cur_prio, clr_pending); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL coin_err: got %0b want 0", err); end
  endtask

  initial begin
    cfg = '0;
    irq_ready = 1'b0;
    mret = 1'b0;
    test_reset();
    test_single_line();
    test_selection();
    test_nesting();
    test_underflow();
    test_hold_and_reset();
    test_coincident();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
